// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

   // Every segment off (active-low lines all high).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low hex patterns, bit6 = a ... bit0 = g, indexed by nibble value.
   localparam logic [6:0] HEX_PAT [16] = '{
      7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
      7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
      7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
      7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
   };

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);

   // Table lookup of the selected nibble.
   always_comb begin
      pat = HEX_PAT[nib];
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with tear-free
// frame-boundary updates, leading-zero suppression and anode dead time.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_DIV    = 50000,
   parameter int unsigned DEAD       = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   data,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      lz_en,
   input  logic                      load,
   output logic                      pending,
   output logic [6:0]                seg,
   output logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     ga,
   output logic                      frame_tick
);

   localparam int unsigned   PW    = cnt_width(CLK_DIV);
   localparam int unsigned   IW    = cnt_width(NUM_DIGITS);
   localparam logic [PW-1:0] PMAX  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PDEAD = PW'(DEAD);
   localparam logic [IW-1:0] IMAX  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]             pcnt;
   logic [IW-1:0]             idx;
   logic                      wrap;
   logic                      boundary;

   logic [4*NUM_DIGITS-1:0]   act_data;
   logic [NUM_DIGITS-1:0]     act_dp;
   logic [NUM_DIGITS-1:0]     act_blank;
   logic [4*NUM_DIGITS-1:0]   sh_data;
   logic [NUM_DIGITS-1:0]     sh_dp;
   logic [NUM_DIGITS-1:0]     sh_blank;

   logic [NUM_DIGITS-1:0]     supp;
   logic                      lz_run;
   logic [3:0]                sel_nib;
   logic                      sel_dp;
   logic                      sel_blank;
   logic                      sel_supp;
   logic [NUM_DIGITS-1:0]     sel_oh;
   logic                      lit;
   logic [6:0]                pat;

   // Slot end and frame end detection.
   always_comb begin
      wrap     = (pcnt == PMAX);
      boundary = wrap && (idx == IMAX);
   end

   // Prescaler and digit index counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (wrap) begin
         pcnt <= '0;
         idx  <= (idx == IMAX) ? '0 : idx + IW'(1);
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   // Shadow capture and frame-boundary transfer into the active registers;
   // a load landing on the boundary itself bypasses the shadow entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         sh_data    <= '0;
         sh_dp      <= '0;
         sh_blank   <= '0;
         pending    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (load) begin
            sh_data  <= data;
            sh_dp    <= dp;
            sh_blank <= blank;
         end
         if (boundary) begin
            pending <= 1'b0;
            if (load) begin
               act_data  <= data;
               act_dp    <= dp;
               act_blank <= blank;
            end else if (pending) begin
               act_data  <= sh_data;
               act_dp    <= sh_dp;
               act_blank <= sh_blank;
            end
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   // Leading-zero suppression: zero, dp-less digits from the top down until
   // the first digit that fails the test; digit 0 is never suppressed.
   always_comb begin
      supp   = '0;
      lz_run = lz_en;
      for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
         lz_run  = lz_run && (act_data[4*k +: 4] == 4'h0) && !act_dp[k];
         supp[k] = lz_run;
      end
   end

   // Select the current digit's attributes and anode.
   always_comb begin
      sel_nib   = '0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      sel_supp  = 1'b0;
      sel_oh    = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            sel_nib   = act_data[4*k +: 4];
            sel_dp    = act_dp[k];
            sel_blank = act_blank[k];
            sel_supp  = supp[k];
            sel_oh[k] = 1'b1;
         end
      end
      lit = (pcnt >= PDEAD) && !sel_blank && !sel_supp;
   end

   seg7_decode u_decode (
      .nib (sel_nib),
      .pat (pat)
   );

   // Registered display outputs, dark during dead time, blank or suppression.
   always_ff @(posedge clk) begin
      if (rst || !lit) begin
         seg  <= SEG_OFF;
         dp_n <= 1'b1;
         ga   <= '1;
      end else begin
         seg  <= pat;
         dp_n <= ~sel_dp;
         ga   <= ~sel_oh;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (4 digits, 8 cycles per slot, 2 dead).
module tb_seg7_scan;

   localparam int ND   = 4;
   localparam int CDIV = 8;
   localparam int DT   = 2;
   localparam int FR   = ND * CDIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  blank = '0;
   logic        lz_en = 1'b0;
   logic        load = 1'b0;
   logic        pending;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  ga;
   logic        frame_tick;

   int n_chk  = 0;
   int n_fail = 0;

   seg7_scan #(.NUM_DIGITS(ND), .CLK_DIV(CDIV), .DEAD(DT)) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .dp         (dp),
      .blank      (blank),
      .lz_en      (lz_en),
      .load       (load),
      .pending    (pending),
      .seg        (seg),
      .dp_n       (dp_n),
      .ga         (ga),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0]  hexpat [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic [15:0] ma_data, ms_data;
   logic [3:0]  ma_dp, ma_blank, ms_dp, ms_blank;
   bit          m_pend;
   bit          m_valid = 0;
   int          t;
   logic [6:0]  e_seg;
   logic [3:0]  e_ga;
   logic        e_dpn;
   logic        e_ft;

   // digit d is dark when it and every digit above it is a plain zero
   function automatic bit suppressed(input int d);
      if (!lz_en || d == 0) return 0;
      for (int j = d; j < ND; j++)
         if (ma_data[4*j +: 4] != 4'h0 || ma_dp[j]) return 0;
      return 1;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            t = 0;
            ma_data = '0; ma_dp = '0; ma_blank = '0;
            ms_data = '0; ms_dp = '0; ms_blank = '0;
            m_pend = 0;
            e_seg = 7'h7F; e_ga = 4'hF; e_dpn = 1'b1; e_ft = 1'b0;
            m_valid = 1;
         end else begin
            int pos, dig;
            bit bnd;
            pos = t % CDIV;
            dig = (t / CDIV) % ND;
            bnd = (t % FR) == FR - 1;
            if (pos >= DT && !ma_blank[dig] && !suppressed(dig)) begin
               e_ga = 4'hF;
               e_ga[dig] = 1'b0;
               e_seg = hexpat[ma_data[4*dig +: 4]];
               e_dpn = ~ma_dp[dig];
            end else begin
               e_ga = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
            end
            e_ft = bnd;
            if (bnd) begin
               if (load) begin
                  ma_data = data; ma_dp = dp; ma_blank = blank;
               end else if (m_pend) begin
                  ma_data = ms_data; ma_dp = ms_dp; ma_blank = ms_blank;
               end
               m_pend = 0;
            end else if (load) begin
               m_pend = 1;
            end
            if (load) begin
               ms_data = data; ms_dp = dp; ms_blank = blank;
            end
            t++;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("m_seg", {9'd0, seg}, {9'd0, e_seg});
            chk("m_ga", {12'd0, ga}, {12'd0, e_ga});
            chk("m_dpn", {15'd0, dp_n}, {15'd0, e_dpn});
            chk("m_pending", {15'd0, pending}, {15'd0, m_pend});
            chk("m_tick", {15'd0, frame_tick}, {15'd0, e_ft});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   int lowcnt [4];

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 3 * FR);
      if (frame_tick !== 1'b1) chk("tick_timeout", 16'd0, 16'd1);
   endtask

   task automatic apply(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      int n;
      wait_tick(n);
      repeat (2) @(negedge clk);
      data = d; dp = p; blank = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("apply_pending", {15'd0, pending}, 16'd1);
      wait_tick(n);
   endtask

   task automatic count_frame();
      for (int i = 0; i < ND; i++) lowcnt[i] = 0;
      repeat (FR) begin
         @(negedge clk);
         for (int i = 0; i < ND; i++) if (ga[i] === 1'b0) lowcnt[i]++;
      end
   endtask

   task automatic expect_digit(input logic [3:0] gav, input logic [6:0] segv,
                               input logic dpv, input string nm);
      int n = 0;
      while (ga !== gav && n < 2 * FR) begin
         @(negedge clk);
         n++;
      end
      if (ga !== gav) chk({nm, "_found"}, {12'd0, ga}, {12'd0, gav});
      else begin
         chk({nm, "_seg"}, {9'd0, seg}, {9'd0, segv});
         chk({nm, "_dpn"}, {15'd0, dp_n}, {15'd0, dpv});
      end
   endtask

   initial begin
      int n;
      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_seg", {9'd0, seg}, 16'h007F);
      chk("rst_ga", {12'd0, ga}, 16'h000F);
      chk("rst_dpn", {15'd0, dp_n}, 16'd1);
      chk("rst_pending", {15'd0, pending}, 16'd0);
      chk("rst_tick", {15'd0, frame_tick}, 16'd0);
      rst = 1'b0;

      // scan order
      apply(16'h1234, 4'b0000, 4'b0000);
      chk("scan_pending_cleared", {15'd0, pending}, 16'd0);
      expect_digit(4'b1110, 7'b1001100, 1'b1, "scan_d0");
      expect_digit(4'b1101, 7'b0000110, 1'b1, "scan_d1");
      expect_digit(4'b1011, 7'b0010010, 1'b1, "scan_d2");
      expect_digit(4'b0111, 7'b1001111, 1'b1, "scan_d3");
      count_frame();
      for (int i = 0; i < ND; i++) chk("scan_lowcnt", 16'(lowcnt[i]), 16'd6);
      wait_tick(n);
      wait_tick(n);
      chk("tick_period", 16'(n), 16'(FR));

      // leading-zero suppression
      lz_en = 1'b1;
      apply(16'h0070, 4'b0000, 4'b0000);
      expect_digit(4'b1110, 7'b0000001, 1'b1, "lz_d0");
      expect_digit(4'b1101, 7'b0001111, 1'b1, "lz_d1");
      count_frame();
      chk("lz_d3_dark", 16'(lowcnt[3]), 16'd0);
      chk("lz_d2_dark", 16'(lowcnt[2]), 16'd0);
      apply(16'h0000, 4'b0000, 4'b0000);
      count_frame();
      chk("lz0_d0", 16'(lowcnt[0]), 16'd6);
      chk("lz0_d1", 16'(lowcnt[1]), 16'd0);
      chk("lz0_d2", 16'(lowcnt[2]), 16'd0);
      chk("lz0_d3", 16'(lowcnt[3]), 16'd0);
      apply(16'h0070, 4'b0100, 4'b0000);
      expect_digit(4'b1011, 7'b0000001, 1'b0, "lzdp_d2");
      count_frame();
      chk("lzdp_d3_dark", 16'(lowcnt[3]), 16'd0);
      lz_en = 1'b0;

      // two loads in one frame: last wins
      wait_tick(n);
      repeat (2) @(negedge clk);
      data = 16'hAAAA; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      data = 16'hBBBB; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_tick(n);
      expect_digit(4'b1110, 7'b1100000, 1'b1, "coll_d0");
      expect_digit(4'b0111, 7'b1100000, 1'b1, "coll_d3");

      // load exactly on the boundary cycle
      wait_tick(n);
      repeat (FR - 1) @(negedge clk);
      data = 16'h5678; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("bnd_tick", {15'd0, frame_tick}, 16'd1);
      chk("bnd_pending", {15'd0, pending}, 16'd0);
      expect_digit(4'b1110, 7'b0000000, 1'b1, "bnd_d0");
      expect_digit(4'b0111, 7'b0100100, 1'b1, "bnd_d3");

      // blank mask
      apply(16'h1234, 4'b0000, 4'b0101);
      count_frame();
      chk("blank_d0", 16'(lowcnt[0]), 16'd0);
      chk("blank_d1", 16'(lowcnt[1]), 16'd6);
      chk("blank_d2", 16'(lowcnt[2]), 16'd0);
      chk("blank_d3", 16'(lowcnt[3]), 16'd6);

      // reset mid-frame, colliding with a load that must be discarded
      apply(16'h9999, 4'b0000, 4'b0000);
      expect_digit(4'b1011, 7'b0000100, 1'b1, "pre_rst_d2");
      rst = 1'b1; data = 16'hFFFF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("mrst_seg", {9'd0, seg}, 16'h007F);
      chk("mrst_ga", {12'd0, ga}, 16'h000F);
      chk("mrst_dpn", {15'd0, dp_n}, 16'd1);
      chk("mrst_pending", {15'd0, pending}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_c2_ga", {12'd0, ga}, 16'h000F);
      @(negedge clk);
      chk("mrst_c3_ga", {12'd0, ga}, 16'h000E);
      chk("mrst_c3_seg", {9'd0, seg}, 16'h0001);
      chk("mrst_c3_pending", {15'd0, pending}, 16'd0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. Holds one hex nibble, decimal point and blank flag per digit and scans them onto shared active-low segment lines with one active-low anode per digit. Updates are tear-free (applied only at frame boundaries), with optional leading-zero suppression and anti-ghosting dead time. Sits between any value-producing logic and the board's display pins. It supersedes the single-digit static decoder.

## Interface
- `NUM_DIGITS`, 4, number of digits and anodes (≥1).
- `CLK_DIV`, 50000, clock cycles per digit slot (≥2).
- `DEAD`, 2, cycles at the start of each slot with all anodes off (0 ≤ DEAD < CLK_DIV).

Ports:
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in 4*NUM_DIGITS: nibble i is `data[4i+3:4i]`; digit 0 is rightmost.
- `dp` in NUM_DIGITS: decimal point per digit, 1 = lit.
- `blank` in NUM_DIGITS: 1 = digit dark.
- `lz_en` in 1: leading-zero suppression enable. Static; sampled every cycle.
- `load` in 1: capture `data`/`dp`/`blank` into the shadow register.
- `pending` out 1: shadow holds an update not yet applied.
- `seg` out 7: active-low segments, bit6 = a … bit0 = g.
- `dp_n` out 1: active-low decimal point.
- `ga` out NUM_DIGITS: active-low anodes, at most one low.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Prescaler.** `pcnt` counts 0..CLK_DIV-1 and wraps.
  - On a wrap, `idx` advances and wraps from NUM_DIGITS-1 to 0.
- **Frame boundary.** The cycle in which `pcnt` wraps while `idx` = NUM_DIGITS-1. In that cycle:
  - active ← shadow if `pending`;
  - `pending` ← 0;
  - `frame_tick` is registered high for the next cycle.
- **Load.**
  - `load` in any cycle writes the shadow and sets `pending`. Last write wins.
  - `load` in the frame-boundary cycle writes the inputs directly to active; `pending` stays 0.
- **Digit lit.** Digit `idx` is lit when `pcnt` ≥ DEAD, its blank flag = 0, and it is not suppressed.
  - When lit: `ga[idx]` = 0, `seg` = hex pattern of the nibble, `dp_n` = ~dp.
  - Otherwise: `ga` all 1, `seg` = 7'h7F, `dp_n` = 1.
- **Leading-zero suppression** (`lz_en` = 1). Scanning from digit NUM_DIGITS-1 downward, each digit with nibble = 0 and dp = 0 is suppressed until the first digit that fails that test.
  - Digit 0 is never suppressed.
  - Computed from active registers only.
- **Hex patterns** (active low, a..g):
  - 0 = 000_0001, 1 = 100_1111, 2 = 001_0010, 3 = 000_0110
  - 4 = 100_1100, 5 = 010_0100, 6 = 010_0000, 7 = 000_1111
  - 8 = 000_0000, 9 = 000_0100, A = 000_1000, b = 110_0000
  - C = 011_0001, d = 100_0010, E = 011_0000, F = 011_1000

## Timing
- **Reset values.**
  - `seg` = 7'h7F, `dp_n` = 1, `ga` = all 1, `pending` = 0, `frame_tick` = 0.
  - `pcnt` = 0, `idx` = 0, active and shadow data/dp = 0, blank = 0.
- **Registered outputs.** `seg`/`dp_n`/`ga` reflect `pcnt`/`idx`/active with 1-cycle latency.
- **Cycles after reset release.** The first cycle after `rst` falls is `pcnt` = 0. Digit 0 anode goes low at cycle DEAD+1.
- **Slot and frame.**
  - Each slot: DEAD cycles dark, then CLK_DIV−DEAD cycles lit.
  - Frame = NUM_DIGITS·CLK_DIV cycles.
  - `frame_tick` period = one frame.
- **Update latency.** An update is visible from the first slot of the next frame: ≤ NUM_DIGITS·CLK_DIV + 1 cycles after `load`.
- **Reset mid-operation.**
  - `rst` overrides `load` and all counting.
  - Outputs are off on the cycle after `rst` is sampled high.
  - Any pending update is discarded.

## Structure
- **Package `seg7_pkg`:**
  - the 16-entry hex pattern constant array;
  - `SEG_OFF` = 7'h7F;
  - a function that computes the prescaler/index counter widths via `$clog2`.
- **Sub-module `seg7_decode`:** combinational, nibble → 7-bit pattern, taken from the package. Instantiated once, on the selected nibble.
- **Top level:** prescaler, index counter, shadow/active registers, suppression logic, output registers.

## Test plan
All scenarios use NUM_DIGITS = 4, CLK_DIV = 8, DEAD = 2.
- **Reset:** `rst` high 3 cycles → `seg` = 7'h7F, `ga` = 4'hF, `dp_n` = 1, `pending` = 0, `frame_tick` = 0.
- **Scan order:** load 16'h1234, blank = 0 → `pending` = 1 until the boundary. Next frame shows:
  - `ga` = 1110 with `seg` = 100_1100;
  - then 1101 with 000_0110;
  - then 1011 with 001_0010;
  - then 0111 with 100_1111.
  - Each anode is low 6 of 8 cycles; `frame_tick` every 32 cycles.
- **Leading-zero suppression:** `lz_en` = 1.
  - data 16'h0070 → digits 3 and 2 dark; digit 1 `seg` = 000_1111; digit 0 `seg` = 000_0001.
  - data 16'h0000 → only digit 0 lit.
  - dp[2] = 1 with 16'h0070 → digit 2 lit as 0 with `dp_n` = 0.
- **Load collisions:**
  - Load 16'hAAAA then 16'hBBBB within one frame → only B (110_0000) is displayed.
  - Load on the boundary cycle → displayed that frame; `pending` never rises.
- **Blank mask:** blank = 4'b0101 → `ga[0]` and `ga[2]` stay 1 all frame.
- **Reset mid-frame:** `rst` asserted during digit 2 → outputs off next cycle; after release, digit 0 shows 0 (000_0001) at cycle 3.
